// File: rtl/stopwatch_ctrl.sv
// Mode controller for the stopwatch: conditions pause/adjust/select, sequences
// RUN / PAUSED / ADJ_SEC / ADJ_MIN and issues one-cycle counter strobes and blink masks.
module stopwatch_ctrl #(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pause,
    input  logic       adjust,
    input  logic       select,
    input  logic       en_1hz,
    input  logic       en_2hz,
    output logic       step,
    output logic       adj_sec,
    output logic       adj_min,
    output logic       blank_sec,
    output logic       blank_min,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PAUSED  = 2'd1,
        ADJ_SEC = 2'd2,
        ADJ_MIN = 2'd3
    } state_t;

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] pause_sync, adjust_sync, select_sync;
    logic                   pause_s, adjust_s, select_s;
    logic                   db_level, db_level_d, press;
    logic [CW-1:0]          db_cnt;
    state_t                 state, state_next;
    logic                   paused, paused_next;
    logic                   phase, phase_next;
    logic                   in_adj;

    assign pause_s  = pause_sync[SYNC_STAGES-1];
    assign adjust_s = adjust_sync[SYNC_STAGES-1];
    assign select_s = select_sync[SYNC_STAGES-1];
    assign in_adj   = (state == ADJ_SEC) || (state == ADJ_MIN);
    assign mode     = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pause_sync  <= '0;
            adjust_sync <= '0;
            select_sync <= '0;
        end else begin
            pause_sync  <= {pause_sync[SYNC_STAGES-2:0], pause};
            adjust_sync <= {adjust_sync[SYNC_STAGES-2:0], adjust};
            select_sync <= {select_sync[SYNC_STAGES-2:0], select};
        end
    end

    // Accepted level moves only after DB_CYCLES consecutive disagreeing samples;
    // press is a registered rising edge of the accepted level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            db_level   <= 1'b0;
            db_level_d <= 1'b0;
            db_cnt     <= '0;
            press      <= 1'b0;
        end else begin
            db_level_d <= db_level;
            press      <= db_level & ~db_level_d;
            if (pause_s == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= pause_s;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        paused_next = paused;
        state_next  = RUN;
        phase_next  = phase;
        if (press && !adjust_s) begin
            paused_next = ~paused;
        end
        if (adjust_s) begin
            state_next = select_s ? ADJ_MIN : ADJ_SEC;
        end else begin
            state_next = paused_next ? PAUSED : RUN;
        end
        // Entering an adjust field (including a field swap) restarts the blink visible.
        if ((state_next == ADJ_SEC || state_next == ADJ_MIN) && state_next != state) begin
            phase_next = 1'b0;
        end else if (in_adj && en_2hz) begin
            phase_next = ~phase;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            paused    <= 1'b0;
            phase     <= 1'b0;
            step      <= 1'b0;
            adj_sec   <= 1'b0;
            adj_min   <= 1'b0;
            blank_sec <= 1'b0;
            blank_min <= 1'b0;
        end else begin
            state     <= state_next;
            paused    <= paused_next;
            phase     <= phase_next;
            step      <= (state == RUN) & en_1hz;
            adj_sec   <= (state == ADJ_SEC) & en_2hz;
            adj_min   <= (state == ADJ_MIN) & en_2hz;
            blank_sec <= (state_next == ADJ_SEC) & phase_next;
            blank_min <= (state_next == ADJ_MIN) & phase_next;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: vector table, directed corner sequences and random
// stimulus, all checked every cycle against a behavioural model.
module tb_stopwatch_ctrl;

    localparam int DB = 4;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pause = 1'b0;
    logic       adjust = 1'b0;
    logic       select = 1'b0;
    logic       en_1hz = 1'b0;
    logic       en_2hz = 1'b0;
    logic       step, adj_sec, adj_min, blank_sec, blank_min;
    logic [1:0] mode;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.DB_CYCLES(DB), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .pause(pause), .adjust(adjust), .select(select),
        .en_1hz(en_1hz), .en_2hz(en_2hz), .step(step), .adj_sec(adj_sec),
        .adj_min(adj_min), .blank_sec(blank_sec), .blank_min(blank_min), .mode(mode)
    );

    // Behavioural model: synchronizers as sample-delay queues, press as a
    // two-edge delayed pulse after the accepted level rises.
    bit         q_p[$], q_a[$], q_s[$], press_q[$];
    bit         m_acc, m_paused, m_phase;
    int         m_run, m_mode;
    logic [6:0] exp_q[$];

    function automatic void model_reset();
        q_p.delete(); q_a.delete(); q_s.delete(); press_q.delete();
        for (int i = 0; i < SS; i++) begin
            q_p.push_back(1'b0); q_a.push_back(1'b0); q_s.push_back(1'b0);
        end
        press_q.push_back(1'b0); press_q.push_back(1'b0);
        m_acc = 0; m_paused = 0; m_phase = 0; m_run = 0; m_mode = 0;
    endfunction

    function automatic logic [6:0] model_step(bit rst_n, bit p, bit a, bit s, bit e1, bit e2);
        bit p_s, a_s, s_s, pr, old_acc, o_step, o_as, o_am;
        int old;
        if (!rst_n) begin
            model_reset();
            return 7'd0;
        end
        p_s = q_p.pop_front(); q_p.push_back(p);
        a_s = q_a.pop_front(); q_a.push_back(a);
        s_s = q_s.pop_front(); q_s.push_back(s);
        pr = press_q.pop_front();
        old_acc = m_acc;
        if (p_s != m_acc) begin
            m_run++;
            if (m_run == DB) begin
                m_acc = p_s;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        press_q.push_back(m_acc && !old_acc);
        old = m_mode;
        o_step = (old == 0) && e1;
        o_as = (old == 2) && e2;
        o_am = (old == 3) && e2;
        if (pr && !a_s) m_paused = !m_paused;
        m_mode = a_s ? (s_s ? 3 : 2) : (m_paused ? 1 : 0);
        if (m_mode >= 2 && m_mode != old) m_phase = 0;
        else if (old >= 2 && e2) m_phase = !m_phase;
        return {o_step, o_as, o_am, (m_mode == 2) && m_phase, (m_mode == 3) && m_phase, 2'(m_mode)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input bit e1, input bit e2);
        en_1hz = e1;
        en_2hz = e2;
        @(posedge clk);
        exp_q.push_back(model_step(reset, pause, adjust, select, e1, e2));
        #1;
        check($sformatf("model@%0t", $time), {step, adj_sec, adj_min, blank_sec, blank_min, mode},
              exp_q.pop_front());
        en_1hz = 1'b0;
        en_2hz = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0);
    endtask

    task automatic press_pause();
        pause = 1'b1;
        idle(10);
        pause = 1'b0;
        idle(10);
    endtask

    typedef struct {
        bit         rst_n, p, a, s, e1, e2;
        logic [6:0] exp;   // {step, adj_sec, adj_min, blank_sec, blank_min, mode}
    } vec_t;

    vec_t tbl[17];
    int   cnt;
    int   p_hold;

    initial begin
        model_reset();
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 7'b0000000};
        tbl[1]  = '{0, 0, 0, 0, 1, 0, 7'b0000000};
        tbl[2]  = '{1, 0, 0, 0, 1, 0, 7'b1000000};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 7'b0000000};
        tbl[4]  = '{1, 0, 0, 0, 1, 0, 7'b1000000};
        tbl[5]  = '{1, 0, 0, 0, 1, 0, 7'b1000000};
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 7'b0000000};
        tbl[7]  = '{1, 0, 1, 0, 0, 0, 7'b0000000};
        tbl[8]  = '{1, 0, 1, 0, 0, 0, 7'b0000000};
        tbl[9]  = '{1, 0, 1, 0, 0, 1, 7'b0000010};
        tbl[10] = '{1, 0, 1, 0, 0, 1, 7'b0101010};
        tbl[11] = '{1, 0, 1, 0, 0, 0, 7'b0001010};
        tbl[12] = '{1, 0, 1, 0, 0, 1, 7'b0100010};
        tbl[13] = '{1, 0, 0, 0, 0, 0, 7'b0000010};
        tbl[14] = '{1, 0, 0, 0, 1, 0, 7'b0000010};
        tbl[15] = '{1, 0, 0, 0, 1, 0, 7'b0000000};
        tbl[16] = '{1, 0, 0, 0, 1, 0, 7'b1000000};

        for (int i = 0; i < 17; i++) begin
            reset = tbl[i].rst_n; pause = tbl[i].p; adjust = tbl[i].a; select = tbl[i].s;
            tick(tbl[i].e1, tbl[i].e2);
            check($sformatf("vec%0d", i), {step, adj_sec, adj_min, blank_sec, blank_min, mode},
                  tbl[i].exp);
        end

        // Clean press: mode flips on the 8th edge after the button edge.
        pause = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 1'b0);
            if (i == 7) check("press_mode_c7", mode, 2'd0);
            if (i == 8) check("press_mode_c8", mode, 2'd1);
        end
        pause = 1'b0;
        idle(10);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0);
            cnt += int'(step);
            idle(2);
        end
        check("paused_steps", cnt, 0);
        press_pause();
        check("second_press_mode", mode, 2'd0);

        // Bounce shorter than the debounce window.
        for (int i = 0; i < 20; i++) begin
            pause = (i % 4) < 2;
            tick(1'b0, 1'b0);
        end
        pause = 1'b0;
        idle(10);
        check("bounce_mode", mode, 2'd0);

        // Seconds adjust with blink, then field swap to minutes.
        adjust = 1'b1; select = 1'b0;
        idle(3);
        check("adj_sec_mode", mode, 2'd2);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b1);
            cnt += int'(adj_sec);
            check($sformatf("blank_sec%0d", k), blank_sec, (k % 2 == 0) ? 1 : 0);
            check($sformatf("blank_min%0d", k), blank_min, 0);
            idle(1);
        end
        check("adj_sec_count", cnt, 4);
        select = 1'b1;
        idle(3);
        check("adj_min_mode", mode, 2'd3);
        check("adj_min_phase_clr", blank_min, 0);
        tick(1'b0, 1'b1);
        check("adj_min_strobe", adj_min, 1);
        check("adj_min_blank", blank_min, 1);

        // Press ignored while adjusting; paused flag preserved.
        adjust = 1'b0; select = 1'b0;
        idle(4);
        check("leave_adj_run", mode, 2'd0);
        press_pause();
        check("paused_again", mode, 2'd1);
        adjust = 1'b1;
        idle(3);
        press_pause();
        adjust = 1'b0;
        idle(4);
        check("ignored_press_mode", mode, 2'd1);
        check("ignored_press_blank", {blank_sec, blank_min}, 2'b00);

        // en_1hz coincident with the edge that pauses.
        press_pause();
        check("resume_run", mode, 2'd0);
        pause = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(i == 8, 1'b0);
            cnt += int'(step);
            if (i == 8) begin
                check("coincident_step", step, 1);
                check("coincident_mode", mode, 2'd1);
            end
        end
        check("coincident_step_count", cnt, 1);
        pause = 1'b0;
        idle(10);
        reset = 1'b0;
        tick(1'b1, 1'b0);
        check("reset_outputs", {step, adj_sec, adj_min, blank_sec, blank_min, mode}, 7'd0);
        reset = 1'b1;
        idle(2);
        check("after_reset_mode", mode, 2'd0);

        // Random stimulus against the model.
        p_hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (p_hold == 0) begin
                pause = 1'($urandom_range(0, 1));
                p_hold = $urandom_range(1, 12);
            end
            p_hold--;
            if ($urandom_range(0, 39) == 0) adjust = ~adjust;
            if ($urandom_range(0, 19) == 0) select = ~select;
            reset = ($urandom_range(0, 299) != 0);
            tick($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
